branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Execute-stage controller that configures and sequences the shared 32-bit magnitude comparator for conditional branches and jumps.
- Selects signed or unsigned compare from funct3 and routes rs1/rs2 to the comparator. Decodes the two comparator result bits into taken/not-taken and computes the target.
- On a taken branch or jump, issues a registered redirect, then holds a flush window that kills wrong-path instructions.
- Keeps wrap-around branch and taken performance counters.

Parameters:
FLUSH_CYCLES, 2, number of cycles flush_o stays asserted after a redirect; legal range 1..15.
CNT_W, 32, width of the performance counters.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous active-high reset
br_valid_i  input  1  EX holds a branch or jump this cycle
br_op_i  input  3  funct3 of the branch
jal_i  input  1  instruction is JAL (unconditional)
jalr_i  input  1  instruction is JALR (unconditional)
stall_i  input  1  pipeline stall; EX does not advance
pc_i  input  32  PC of the EX instruction
imm_i  input  32  sign-extended immediate
rs1_i  input  32  rs1 operand
rs2_i  input  32  rs2 operand
cmp_sign_o  output  1  drives comparator sign-select
cmp_a_o  output  32  comparator operand a (= rs1_i)
cmp_b_o  output  32  comparator operand b (= rs2_i)
cmp_res_i  input  2  comparator result: bit1 = less-than, bit0 = equal
redirect_o  output  1  one-cycle redirect pulse
redirect_pc_o  output  32  fetch target, valid while redirect_o = 1
flush_o  output  1  kill wrong-path instructions in IF/ID
illegal_o  output  1  one-cycle pulse for an unsupported funct3
br_cnt_o  output  CNT_W  accepted branches and jumps
taken_cnt_o  output  CNT_W  taken branches and jumps

Behaviour:
- Reset: synchronous and active-high. On a clock edge with rst_i = 1:
  - state = IDLE, flush counter = 0.
  - redirect_o, flush_o, illegal_o, redirect_pc_o, br_cnt_o, taken_cnt_o all = 0.
  - Reset asserted during FLUSH aborts the window; flush_o = 0 on the following cycle.
- Comparator drive (combinational, every cycle):
  - cmp_a_o = rs1_i, cmp_b_o = rs2_i.
  - cmp_sign_o = ~br_op_i[1]: signed for 100/101, unsigned for 110/111. Don't-care for 000/001.
- Taken decode by funct3:
  - 000: eq. 001: ~eq.
  - 100 and 110: lt. 101 and 111: ~lt.
  - 010 and 011: not taken; illegal_o pulses 1 on the next cycle.
  - jal_i or jalr_i overrides funct3: always taken, never illegal.
- Targets (mod 2^32):
  - Branch and JAL: pc_i + imm_i.
  - JALR: (rs1_i + imm_i) with bit0 cleared.
- Accept condition: br_valid_i & ~stall_i & state == IDLE & ~rst_i, sampled at the rising edge.
  - br_valid_i in any other state or cycle is ignored: no counting, no redirect.
- Latency, instruction accepted at edge N:
  - Cycle N+1: br_cnt_o has incremented by 1.
  - If taken:
    - taken_cnt_o has also incremented.
    - redirect_o = 1 for exactly that cycle, with redirect_pc_o = target.
    - flush_o = 1, state = FLUSH, counter = FLUSH_CYCLES.
  - If not taken: no redirect, state stays IDLE.
- FLUSH state:
  - flush_o = 1.
  - Counter decrements on each edge where stall_i = 0 and freezes while stall_i = 1.
  - On the edge where the counter goes 1 -> 0: state = IDLE and flush_o = 0 from the next cycle.
  - Net result: flush_o is high for exactly FLUSH_CYCLES unstalled cycles.
- redirect_o is never delayed by stall_i and never asserts twice per accepted instruction.
- redirect_pc_o holds its last value when redirect_o = 0.
- Counters wrap from 2^CNT_W-1 to 0 with no saturation.

Test Plan:
- BLT signed: rs1 = 0xFFFFFFFF, rs2 = 1, cmp_res = 2'b10, pc = 0x100, imm = 0x20 -> cmp_sign_o = 1; next cycle redirect_o = 1, redirect_pc_o = 0x120, flush_o high for 2 cycles; taken_cnt_o = 1.
- BLTU: same operands, cmp_res = 2'b00 -> cmp_sign_o = 0; no redirect; br_cnt_o = 1, taken_cnt_o = 0; flush_o stays 0.
- JALR: rs1 = 0x1003, imm = 0x4 -> redirect_pc_o = 0x1006; taken regardless of cmp_res.
- funct3 = 010 with br_valid_i -> illegal_o pulses one cycle; no redirect; br_cnt_o increments.
- During FLUSH, drive br_valid_i each cycle plus one stall cycle -> all ignored; flush_o high for 3 cycles; then a BEQ with cmp_res = 2'b01 is accepted.
- Assert rst_i in the first FLUSH cycle -> next cycle flush_o = 0, counters = 0, state IDLE; a BNE issued right after is accepted normally.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch/jump resolver: drives the shared comparator, decodes taken,
// issues a registered redirect plus flush window, and counts branches/taken.
module branch_resolve_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             br_valid_i,
    input  logic [2:0]       br_op_i,
    input  logic             jal_i,
    input  logic             jalr_i,
    input  logic             stall_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      imm_i,
    input  logic [31:0]      rs1_i,
    input  logic [31:0]      rs2_i,
    output logic             cmp_sign_o,
    output logic [31:0]      cmp_a_o,
    output logic [31:0]      cmp_b_o,
    input  logic [1:0]       cmp_res_i,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t           state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic             redirect_q, redirect_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic        accept;
    logic        uncond;
    logic        is_lt, is_eq;
    logic        taken;
    logic        op_illegal;
    logic [31:0] target;
    logic [31:0] jalr_sum;

    assign cmp_a_o    = rs1_i;
    assign cmp_b_o    = rs2_i;
    assign cmp_sign_o = ~br_op_i[1];

    assign is_lt    = cmp_res_i[1];
    assign is_eq    = cmp_res_i[0];
    assign uncond   = jal_i | jalr_i;
    assign jalr_sum = rs1_i + imm_i;
    assign accept   = br_valid_i & ~stall_i & (state_q == IDLE);

    always_comb begin
        taken      = 1'b0;
        op_illegal = 1'b0;
        target     = pc_i + imm_i;
        if (uncond) begin
            taken = 1'b1;
            if (jalr_i) begin
                target = {jalr_sum[31:1], 1'b0};
            end
        end else begin
            case (br_op_i)
                3'b000:         taken = is_eq;
                3'b001:         taken = ~is_eq;
                3'b100, 3'b110: taken = is_lt;
                3'b101, 3'b111: taken = ~is_lt;
                default:        op_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        illegal_d     = 1'b0;
        br_cnt_d      = br_cnt_q;
        taken_cnt_d   = taken_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    br_cnt_d  = br_cnt_q + 1'b1;
                    illegal_d = op_illegal;
                    if (taken) begin
                        taken_cnt_d   = taken_cnt_q + 1'b1;
                        redirect_d    = 1'b1;
                        redirect_pc_d = target;
                        state_d       = FLUSH;
                        flush_cnt_d   = FLUSH_INIT;
                    end
                end
            end
            FLUSH: begin
                // The window only drains on cycles where the front end actually moves.
                if (!stall_i) begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                    if (flush_cnt_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            flush_cnt_q   <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            illegal_q     <= 1'b0;
            br_cnt_q      <= '0;
            taken_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            illegal_q     <= illegal_d;
            br_cnt_q      <= br_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
        end
    end

    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign flush_o       = (state_q == FLUSH);
    assign illegal_o     = illegal_q;
    assign br_cnt_o      = br_cnt_q;
    assign taken_cnt_o   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: linear stimulus, hand-computed expectations.
module tb_branch_resolve_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        br_valid_i;
    logic [2:0]  br_op_i;
    logic        jal_i;
    logic        jalr_i;
    logic        stall_i;
    logic [31:0] pc_i;
    logic [31:0] imm_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        cmp_sign_o;
    logic [31:0] cmp_a_o;
    logic [31:0] cmp_b_o;
    logic [1:0]  cmp_res_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        illegal_o;
    logic [31:0] br_cnt_o;
    logic [31:0] taken_cnt_o;

    int tests = 0;
    int fails = 0;

    branch_resolve_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .br_valid_i(br_valid_i), .br_op_i(br_op_i),
        .jal_i(jal_i), .jalr_i(jalr_i), .stall_i(stall_i), .pc_i(pc_i), .imm_i(imm_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .cmp_sign_o(cmp_sign_o), .cmp_a_o(cmp_a_o),
        .cmp_b_o(cmp_b_o), .cmp_res_i(cmp_res_i), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o), .flush_o(flush_o), .illegal_o(illegal_o),
        .br_cnt_o(br_cnt_o), .taken_cnt_o(taken_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic rd, input logic [31:0] rpc,
                           input logic fl, input logic il,
                           input logic [31:0] bc, input logic [31:0] tc);
        check({tag, ".redirect"}, {31'd0, redirect_o}, {31'd0, rd});
        check({tag, ".redirect_pc"}, redirect_pc_o, rpc);
        check({tag, ".flush"}, {31'd0, flush_o}, {31'd0, fl});
        check({tag, ".illegal"}, {31'd0, illegal_o}, {31'd0, il});
        check({tag, ".br_cnt"}, br_cnt_o, bc);
        check({tag, ".taken_cnt"}, taken_cnt_o, tc);
    endtask

    initial begin
        rst_i = 1'b1; br_valid_i = 1'b0; br_op_i = 3'b000; jal_i = 1'b0; jalr_i = 1'b0;
        stall_i = 1'b0; pc_i = '0; imm_i = '0; rs1_i = '0; rs2_i = '0; cmp_res_i = 2'b00;
        step(); step();
        chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
        rst_i = 1'b0;

        // BLT signed, taken
        br_op_i = 3'b100; rs1_i = 32'hFFFF_FFFF; rs2_i = 32'd1; cmp_res_i = 2'b10;
        pc_i = 32'h100; imm_i = 32'h20; br_valid_i = 1'b1;
        #1;
        check("blt.cmp_sign", {31'd0, cmp_sign_o}, 32'd1);
        check("blt.cmp_a", cmp_a_o, 32'hFFFF_FFFF);
        check("blt.cmp_b", cmp_b_o, 32'd1);
        step(); br_valid_i = 1'b0;
        chk_out("blt.n1", 1'b1, 32'h120, 1'b1, 1'b0, 32'd1, 32'd1);
        step();
        chk_out("blt.n2", 1'b0, 32'h120, 1'b1, 1'b0, 32'd1, 32'd1);
        step();
        chk_out("blt.n3", 1'b0, 32'h120, 1'b0, 1'b0, 32'd1, 32'd1);

        // BLTU, not taken
        br_op_i = 3'b110; cmp_res_i = 2'b00; br_valid_i = 1'b1;
        #1;
        check("bltu.cmp_sign", {31'd0, cmp_sign_o}, 32'd0);
        step(); br_valid_i = 1'b0;
        chk_out("bltu.n1", 1'b0, 32'h120, 1'b0, 1'b0, 32'd2, 32'd1);

        // JALR: target bit0 cleared, cmp_res irrelevant
        jalr_i = 1'b1; br_op_i = 3'b000; rs1_i = 32'h1003; imm_i = 32'h4; cmp_res_i = 2'b00;
        br_valid_i = 1'b1;
        step(); br_valid_i = 1'b0; jalr_i = 1'b0;
        chk_out("jalr.n1", 1'b1, 32'h1006, 1'b1, 1'b0, 32'd3, 32'd2);
        step(); step();
        check("jalr.flush_end", {31'd0, flush_o}, 32'd0);

        // Illegal funct3
        br_op_i = 3'b010; br_valid_i = 1'b1;
        step(); br_valid_i = 1'b0;
        chk_out("ill.n1", 1'b0, 32'h1006, 1'b0, 1'b1, 32'd4, 32'd2);
        step();
        check("ill.n2", {31'd0, illegal_o}, 32'd0);

        // JAL then stray valids plus a stall during FLUSH
        jal_i = 1'b1; pc_i = 32'h200; imm_i = 32'h10; br_valid_i = 1'b1;
        step();
        chk_out("jal.n1", 1'b1, 32'h210, 1'b1, 1'b0, 32'd5, 32'd3);
        jal_i = 1'b0; br_op_i = 3'b000; cmp_res_i = 2'b01; stall_i = 1'b1;
        step();
        chk_out("fl.stall", 1'b0, 32'h210, 1'b1, 1'b0, 32'd5, 32'd3);
        stall_i = 1'b0;
        step();
        chk_out("fl.c2", 1'b0, 32'h210, 1'b1, 1'b0, 32'd5, 32'd3);
        step();
        chk_out("fl.done", 1'b0, 32'h210, 1'b0, 1'b0, 32'd5, 32'd3);
        pc_i = 32'h300; imm_i = 32'h8;
        step(); br_valid_i = 1'b0;
        chk_out("beq.n1", 1'b1, 32'h308, 1'b1, 1'b0, 32'd6, 32'd4);
        step(); step();
        check("beq.flush_end", {31'd0, flush_o}, 32'd0);

        // BNE taken, then reset in the first FLUSH cycle
        br_op_i = 3'b001; cmp_res_i = 2'b00; pc_i = 32'h400; imm_i = 32'h40; br_valid_i = 1'b1;
        step(); br_valid_i = 1'b0;
        chk_out("bne.n1", 1'b1, 32'h440, 1'b1, 1'b0, 32'd7, 32'd5);
        rst_i = 1'b1;
        step(); rst_i = 1'b0;
        chk_out("rst.fl", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
        pc_i = 32'h500; imm_i = 32'hFFFF_FFF0; br_valid_i = 1'b1;
        step(); br_valid_i = 1'b0;
        chk_out("bne2.n1", 1'b1, 32'h4F0, 1'b1, 1'b0, 32'd1, 32'd1);
        step();
        check("bne2.n2", {31'd0, flush_o}, 32'd1);
        step();
        check("bne2.n3", {31'd0, flush_o}, 32'd0);

        // BGE signed, not taken when lt
        br_op_i = 3'b101; cmp_res_i = 2'b10; br_valid_i = 1'b1;
        #1;
        check("bge.cmp_sign", {31'd0, cmp_sign_o}, 32'd1);
        step(); br_valid_i = 1'b0;
        chk_out("bge.n1", 1'b0, 32'h4F0, 1'b0, 1'b0, 32'd2, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
